// File: rtl/reg_arb_pkg.sv
// Shared types and default parameters for the reg_write_arbiter slice.
package reg_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ACK  = 2'b10
  } arb_state_t;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_WIDTH = 8;

endpackage : reg_arb_pkg

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the shared-register write arbiter.
//   req    : per-requester write request (bit i = requester i)
//   wdata  : requester i data at [i*WIDTH +: WIDTH]
//   ack    : per-requester acknowledge, one-hot or zero
//   q      : shared register contents
//   gnt_id : index of current or last winner
//   busy   : arbiter is in LOAD or ACK
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic [IDW-1:0]        gnt_id;
  logic                  busy;

  // Requesters drive req/wdata
  modport master (output req, wdata, input ack, q, gnt_id, busy);
  // Arbiter owns ack/q/gnt_id/busy
  modport slave  (input req, wdata, output ack, q, gnt_id, busy);

endinterface : reg_write_arbiter_if

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// searching upward modulo NREQ.
//   req   : request vector
//   ptr   : highest-priority index
//   valid : any request present
//   idx   : winning index (0 when !valid)
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  // Rank each request by its distance above ptr; smallest distance wins.
  always_comb begin
    int unsigned d;
    int unsigned best;
    valid = 1'b0;
    idx   = '0;
    best  = NREQ;
    d     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        d = (i + NREQ - 32'(ptr)) % NREQ;
        if (d < best) begin
          best  = d;
          idx   = IDW'(i);
          valid = 1'b1;
        end
      end
    end
  end

endmodule : rr_pick

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter owning one shared WIDTH-bit register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requester bus (slave side): req/wdata in, ack/q/gnt_id/busy out
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_write_arbiter_if.slave   bus
);

  localparam int unsigned IDW = $clog2(NREQ);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [IDW-1:0]   r_gnt_id;
  logic [IDW-1:0]   w_gnt_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [NREQ-1:0]  r_ack;
  logic [NREQ-1:0]  w_ack_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_pick_valid;
  logic [IDW-1:0]   w_pick_idx;
  logic [WIDTH-1:0] w_wsel;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  // Winner's write data
  always_comb begin
    w_wsel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_gnt_id == IDW'(i)) w_wsel = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  // Next state; ack/busy are precomputed from the next state so they
  // come straight out of flops with no path from req.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt_id;
    w_q_nxt     = r_q;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_gnt_nxt   = w_pick_idx;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_q_nxt     = w_wsel;
        w_state_nxt = ACK;
      end
      ACK: begin
        if (!bus.req[r_gnt_id]) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
    w_ack_nxt  = (w_state_nxt == ACK) ? (NREQ'(1) << w_gnt_nxt) : '0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
      r_q      <= '0;
      r_ack    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_gnt_id <= w_gnt_nxt;
      r_q      <= w_q_nxt;
      r_ack    <= w_ack_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.ack    = r_ack;
  assign bus.q      = r_q;
  assign bus.gnt_id = r_gnt_id;
  assign bus.busy   = r_busy;

endmodule : reg_write_arbiter

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (NREQ=4 and NREQ=3) and rr_pick.
module tb_reg_write_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NREQ(4), .WIDTH(8)) bus4 ();
  reg_write_arbiter_if #(.NREQ(3), .WIDTH(8)) bus3 ();

  reg_write_arbiter #(.NREQ(4), .WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );
  reg_write_arbiter #(.NREQ(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
  );

  logic [2:0] pk_req;
  logic [1:0] pk_ptr;
  logic       pk_valid;
  logic [1:0] pk_idx;
  rr_pick #(.NREQ(3)) u_pk (
    .req(pk_req), .ptr(pk_ptr), .valid(pk_valid), .idx(pk_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for any ack; returns number of negedges waited
  task automatic wait_ack4(output int n);
    n = 0;
    while (bus4.ack == 4'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ack4_seen", 32'(bus4.ack != 4'b0), 32'd1);
  endtask

  task automatic wait_ack3(output int n);
    n = 0;
    while (bus3.ack == 3'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ack3_seen", 32'(bus3.ack != 3'b0), 32'd1);
  endtask

  // Expect requester exp to be served with data expq, then drop its req
  task automatic serve4(input int exp, input logic [7:0] expq, input bit rearm);
    int n;
    wait_ack4(n);
    check("lat4",  32'(n), 32'd2);
    check("gnt4",  32'(bus4.gnt_id), 32'(exp));
    check("ack4",  32'(bus4.ack), 32'(4'(1) << exp));
    check("q4",    32'(bus4.q), 32'(expq));
    check("busy4", 32'(bus4.busy), 32'd1);
    bus4.req = bus4.req & ~(4'(1) << exp);
    @(negedge clk);
    check("ack4_low",  32'(bus4.ack), 32'd0);
    check("busy4_low", 32'(bus4.busy), 32'd0);
    if (rearm) bus4.req = bus4.req | (4'(1) << exp);
  endtask

  task automatic serve3(input int exp, input logic [7:0] expq, input bit rearm);
    int n;
    wait_ack3(n);
    check("lat3", 32'(n), 32'd2);
    check("gnt3", 32'(bus3.gnt_id), 32'(exp));
    check("ack3", 32'(bus3.ack), 32'(3'(1) << exp));
    check("q3",   32'(bus3.q), 32'(expq));
    bus3.req = bus3.req & ~(3'(1) << exp);
    @(negedge clk);
    check("ack3_low",  32'(bus3.ack), 32'd0);
    check("busy3_low", 32'(bus3.busy), 32'd0);
    if (rearm) bus3.req = bus3.req | (3'(1) << exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus4.req = '0; bus4.wdata = '0;
    bus3.req = '0; bus3.wdata = '0;

    // Standalone picker, NREQ=3
    pk_req = 3'b011; pk_ptr = 2'd2; #1;
    check("pk_wrap_valid", 32'(pk_valid), 32'd1);
    check("pk_wrap_idx",   32'(pk_idx), 32'd0);
    pk_req = 3'b000; pk_ptr = 2'd1; #1;
    check("pk_none", 32'(pk_valid), 32'd0);
    pk_req = 3'b110; pk_ptr = 2'd0; #1;
    check("pk_110_p0", 32'(pk_idx), 32'd1);
    pk_req = 3'b101; pk_ptr = 2'd1; #1;
    check("pk_101_p1", 32'(pk_idx), 32'd2);
    pk_req = 3'b001; pk_ptr = 2'd1; #1;
    check("pk_001_p1", 32'(pk_idx), 32'd0);

    // Reset, then idle
    repeat (3) @(negedge clk);
    check("rst_q",    32'(bus4.q), 32'd0);
    check("rst_gnt",  32'(bus4.gnt_id), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_q",    32'(bus4.q), 32'd0);
      check("idle_ack",  32'(bus4.ack), 32'd0);
      check("idle_busy", 32'(bus4.busy), 32'd0);
    end

    // Rotation with all four requesting
    bus4.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus4.req   = 4'hF;
    serve4(0, 8'h11, 1'b1);
    serve4(1, 8'h22, 1'b1);
    serve4(2, 8'h33, 1'b1);
    serve4(3, 8'h44, 1'b1);
    serve4(0, 8'h11, 1'b0);
    bus4.req = '0;
    @(negedge clk);
    check("rot_idle_busy", 32'(bus4.busy), 32'd0);

    // Single write from requester 2
    bus4.wdata[23:16] = 8'hA5;
    bus4.req = 4'b0100;
    @(negedge clk);
    check("sw_busy",  32'(bus4.busy), 32'd1);
    check("sw_gnt",   32'(bus4.gnt_id), 32'd2);
    check("sw_ack0",  32'(bus4.ack), 32'd0);
    check("sw_qhold", 32'(bus4.q), 32'h11);
    @(negedge clk);
    check("sw_q",   32'(bus4.q), 32'hA5);
    check("sw_ack", 32'(bus4.ack), 32'b0100);
    bus4.req = '0;
    @(negedge clk);
    check("sw_ack_low",  32'(bus4.ack), 32'd0);
    check("sw_busy_low", 32'(bus4.busy), 32'd0);
    check("sw_q_hold",   32'(bus4.q), 32'hA5);

    // Early drop of req[1] during LOAD
    bus4.wdata[15:8] = 8'h3C;
    bus4.req = 4'b0010;
    @(negedge clk);
    check("ed_busy", 32'(bus4.busy), 32'd1);
    check("ed_gnt",  32'(bus4.gnt_id), 32'd1);
    bus4.req = '0;
    @(negedge clk);
    check("ed_ack", 32'(bus4.ack), 32'b0010);
    check("ed_q",   32'(bus4.q), 32'h3C);
    @(negedge clk);
    check("ed_ack_low",  32'(bus4.ack), 32'd0);
    check("ed_busy_low", 32'(bus4.busy), 32'd0);
    @(negedge clk);
    check("ed_stay_idle", 32'(bus4.busy), 32'd0);

    // Reset mid-transaction while in ACK
    bus4.wdata[31:24] = 8'h77;
    bus4.req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    check("rm_ack", 32'(bus4.ack), 32'b1000);
    check("rm_q",   32'(bus4.q), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    check("rm_rst_q",    32'(bus4.q), 32'd0);
    check("rm_rst_ack",  32'(bus4.ack), 32'd0);
    check("rm_rst_busy", 32'(bus4.busy), 32'd0);
    check("rm_rst_gnt",  32'(bus4.gnt_id), 32'd0);
    @(negedge clk);
    bus4.req = 4'hF;
    rst_n = 1'b1;
    @(negedge clk);
    check("rm_first_busy", 32'(bus4.busy), 32'd1);
    check("rm_first_gnt",  32'(bus4.gnt_id), 32'd0);
    @(negedge clk);
    check("rm_first_ack", 32'(bus4.ack), 32'b0001);
    check("rm_first_q",   32'(bus4.q), 32'h11);
    bus4.req = '0;
    @(negedge clk);
    check("rm_done_ack", 32'(bus4.ack), 32'd0);

    // NREQ=3: wrap from 2 back to 0
    bus3.wdata = {8'h5A, 8'hB2, 8'hA1};
    bus3.req = 3'b100;
    serve3(2, 8'h5A, 1'b0);
    bus3.req = 3'b011;
    serve3(0, 8'hA1, 1'b0);
    bus3.req = '0;
    @(negedge clk);
    bus3.req = 3'b111;
    serve3(1, 8'hB2, 1'b1);
    serve3(2, 8'h5A, 1'b1);
    serve3(0, 8'hA1, 1'b0);
    bus3.req = '0;
    @(negedge clk);
    check("n3_idle", 32'(bus3.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_write_arbiter

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter for one shared WIDTH-bit D-type register. Up to NREQ requesters contend for write access with a four-phase req/ack handshake. The block selects one winner, loads that requester's data into the register on a single clock edge, and acknowledges the winner. It owns the shared register, so `q` is the architectural register value seen by the rest of the design.

## Interface
- `NREQ`, default 4: number of requesters, ≥2; need not be a power of two.
- `WIDTH`, default 8: register width, ≥1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  NREQ  per-requester write request (bit i = requester i).
- `wdata`  in  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
- `ack`  out  NREQ  per-requester acknowledge; at most one bit high at a time.
- `q`  out  WIDTH  shared register contents.
- `gnt_id`  out  $clog2(NREQ)  index of the current or last winner.
- `busy`  out  1  high while in LOAD or ACK.

## Operation
- FSM has three states: IDLE, LOAD and ACK.
- IDLE
  - If `req` != 0, pick the first set bit starting at `ptr` and searching upward modulo NREQ.
  - Register the winner into `gnt_id` and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD
  - `q` <= `wdata[gnt_id]` at the end of this cycle, then go to ACK.
  - The register is written only here; `q` holds in every other state.
- ACK
  - `ack[gnt_id]` = 1.
  - When `req[gnt_id]` is sampled 0: set `ptr` <= (`gnt_id`+1) mod NREQ and go to IDLE.
- Round-robin fairness
  - `ptr` changes only on ACK→IDLE.
  - The winner has lowest priority in the next arbitration.
  - Wrap-around is from NREQ-1 to 0, including for non-power-of-two NREQ.
- Requester obligations
  - Hold `wdata` stable from `req` rise until `ack` is seen.
  - Drop `req` after `ack`.
  - Do not re-raise `req` until `ack` is low.
- Protocol violations have defined behaviour:
  - `req` dropped in LOAD: the load still completes, `ack` pulses for exactly one cycle, then IDLE.
  - Non-winner `req` changes during LOAD/ACK are ignored until the next IDLE.
- Outputs are registered or decoded only from state and `gnt_id`; there is no combinational path from `req` to `ack`.

## Timing
- Reset values: state=IDLE, `q`=0, `ack`=0, `gnt_id`=0, `busy`=0, `ptr`=0.
- Reset asserted mid-transaction aborts immediately. `q` is cleared even if LOAD was in progress.
- Latency, with edges labelled:
  - E1: `req` sampled high in IDLE.
  - After E1: `busy`=1 and `gnt_id` is valid.
  - E2: `q` updated.
  - After E2: `ack` is high.
  - Edge Ek: first edge where `req[gnt_id]`=0 is sampled.
  - After Ek: `ack`=0, `busy`=0, IDLE.
- Minimum transaction is 3 cycles (IDLE, LOAD, ACK). Peak throughput is one write per 3 cycles.
- A new request present in the IDLE cycle after ACK is granted on that IDLE edge; there are no extra bubbles.
- `ack` is high for at least 1 cycle per grant.

## Structure
- Package `reg_arb_pkg` holds:
  - `arb_state_t` enum: IDLE=2'b00, LOAD=2'b01, ACK=2'b10.
  - Default parameter constants.
- Natural sub-module `rr_pick`: a purely combinational round-robin picker.
  - Inputs: `req`, `ptr`.
  - Outputs: `valid`, `idx`.
  - Verified standalone.
- The FSM, `ptr`, `gnt_id` and the `q` register stay in the top module.

## Test plan
- Reset then idle: hold `rst_n`=0, then release with `req`=0 → `q`=0, `ack`=0, `busy`=0 for 10 cycles.
- Single write: `req`=4'b0100, `wdata[2]`=8'hA5 → LOAD one cycle after sampling, `q`=8'hA5, `ack`=4'b0100; drop `req` → `ack` low next cycle.
- Rotation: all four `req` held and each requester drops/re-raises after `ack` → grant order 0,1,2,3,0 and `q` follows each requester's data.
- Wrap/non-pow2: NREQ=3, `ptr`=2, `req`=3'b011 → winner 0. Last winner 2 with all requesting → next winner 0.
- Early drop: `req[1]` deasserted during LOAD with `wdata[1]`=8'h3C → `q`=8'h3C, `ack[1]` high exactly 1 cycle, back to IDLE.
- Reset mid-op: `rst_n` pulled low in ACK → asynchronously `q`=0, `ack`=0, `busy`=0, `gnt_id`=0; the first grant after release goes to requester 0 if it is requesting.
